// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Result and overflow are held between completions for the downstream BCD adder.
module bin_to_bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [BIN_W-1:0] shift_q, shift_d;
   logic [BW-1:0]    scr_q, scr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovs_q, ovs_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic             ovf_q, ovf_d;

   logic [BW-1:0]    corr;
   logic [BW-1:0]    scr_sh;
   logic             top_bit;
   logic             last;

   // Add-3 correction on every digit in parallel, ahead of the shift.
   always_comb begin
      corr = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5)
            corr[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
         else
            corr[4*i +: 4] = scr_q[4*i +: 4];
      end
   end

   assign scr_sh  = {corr[BW-2:0], shift_q[BIN_W-1]};
   assign top_bit = corr[BW-1];
   assign last    = (cnt_q == CW'(BIN_W - 1));

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      ovs_d   = ovs_q;
      bcd_d   = bcd_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               state_d = CONVERT;
               shift_d = bin;
               scr_d   = '0;
               cnt_d   = '0;
               ovs_d   = 1'b0;
            end
         end
         CONVERT: begin
            shift_d = shift_q << 1;
            scr_d   = scr_sh;
            ovs_d   = ovs_q | top_bit;
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               bcd_d   = scr_sh;
               ovf_d   = ovs_q | top_bit;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         ovs_q   <= 1'b0;
         bcd_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         ovs_q   <= ovs_d;
         bcd_q   <= bcd_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = (state_q == CONVERT);
   assign done     = (state_q == DONE);
   assign bcd      = bcd_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: table vectors through a scoreboard plus
// back-to-back, ignored-start, async-reset and 2-digit overflow sequences.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  bin = '0;
   logic        busy, done, overflow;
   logic [11:0] bcd;

   logic        start2 = 1'b0;
   logic [7:0]  bin2 = '0;
   logic        busy2, done2, overflow2;
   logic [7:0]  bcd2;

   int n_vec = 0;
   int n_err = 0;

   logic [12:0] exp_q[$];

   typedef struct {
      logic [7:0]  b;
      logic [11:0] e;
   } vec_t;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
   );

   bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
      .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Scoreboard: every done pulse pops one expected {overflow, bcd}.
   always @(negedge clk) begin
      logic [12:0] e;
      if (rst_n && done) begin
         chk("busy_and_done", {31'd0, busy}, 32'd0);
         if (exp_q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("result", {19'd0, overflow, bcd}, {19'd0, e});
         end
      end
   end

   // Start one conversion, then track busy length and done arrival.
   task automatic convert(input logic [7:0] v, input logic [11:0] e);
      int nb;
      bit got;
      nb = 0;
      got = 0;
      start = 1'b1;
      bin = v;
      exp_q.push_back({1'b0, e});
      @(negedge clk);
      start = 1'b0;
      bin = 8'($urandom);
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            got = 1;
            break;
         end
         if (busy) nb++;
         @(negedge clk);
      end
      chk("done_seen", {31'd0, got}, 32'd1);
      chk("busy_cycles", nb, 8);
      @(negedge clk);
   endtask

   task automatic convert2(input logic [7:0] v, input logic [7:0] e,
                           input logic eo);
      bit got;
      got = 0;
      start2 = 1'b1;
      bin2 = v;
      @(negedge clk);
      start2 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done2) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      chk("done2_seen", {31'd0, got}, 32'd1);
      chk("bcd2", {24'd0, bcd2}, {24'd0, e});
      chk("ovf2", {31'd0, overflow2}, {31'd0, eo});
      @(negedge clk);
   endtask

   initial begin
      vec_t vt[8];
      int   nd;
      int   gap;
      bit   seen;

      vt[0] = '{8'd0,   12'h000};
      vt[1] = '{8'd255, 12'h255};
      vt[2] = '{8'd99,  12'h099};
      vt[3] = '{8'd5,   12'h005};
      vt[4] = '{8'd10,  12'h010};
      vt[5] = '{8'd128, 12'h128};
      vt[6] = '{8'd9,   12'h009};
      vt[7] = '{8'd100, 12'h100};

      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_bcd", {20'd0, bcd}, 32'd0);
      chk("rst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) convert(vt[i].b, vt[i].e);

      // Start held high: second accept happens in the DONE cycle.
      start = 1'b1;
      bin = 8'd37;
      exp_q.push_back({1'b0, 12'h037});
      exp_q.push_back({1'b0, 12'h142});
      @(negedge clk);
      bin = 8'd142;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            seen = 1;
            break;
         end
         @(negedge clk);
      end
      chk("b2b_first", {31'd0, seen}, 32'd1);
      gap = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         gap++;
         if (gap == 1) start = 1'b0;
         if (done) begin
            seen = 1;
            break;
         end
      end
      chk("b2b_second", {31'd0, seen}, 32'd1);
      chk("b2b_gap", gap, 9);
      @(negedge clk);
      chk("b2b_idle", {30'd0, busy, done}, 32'd0);

      // Start and bin wiggled during CONVERT must be ignored.
      start = 1'b1;
      bin = 8'd123;
      exp_q.push_back({1'b0, 12'h123});
      @(negedge clk);
      start = 1'b0;
      nd = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            seen = 1;
            break;
         end
         if (busy) nd++;
         start = (i == 2 || i == 5) ? 1'b1 : 1'b0;
         bin = 8'($urandom);
         @(negedge clk);
      end
      start = 1'b0;
      chk("ign_done", {31'd0, seen}, 32'd1);
      chk("ign_busy", nd, 8);
      @(negedge clk);

      // Asynchronous reset in the middle of converting 200.
      start = 1'b1;
      bin = 8'd200;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_bcd", {20'd0, bcd}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) nd++;
      end
      chk("arst_quiet", nd, 0);
      chk("arst_hold", {20'd0, bcd}, 32'd0);
      convert(8'd200, 12'h200);

      // Two-digit instance: overflow set, then cleared by next result.
      convert2(8'd255, 8'h55, 1'b1);
      convert2(8'd99, 8'h99, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule
